// File: rtl/video_pkg.sv
// Shared video definitions: coordinate and colour widths, default image size,
// and small helpers for sync edge detection and saturating position counters.
package video_pkg;

  localparam int COORD_W   = 11;
  localparam int RGB_W     = 24;
  localparam int DIFF_W    = COORD_W + 1;
  localparam int DEF_IMG_W = 64;
  localparam int DEF_IMG_H = 64;

  typedef logic [COORD_W-1:0]       coord_t;
  typedef logic [RGB_W-1:0]         rgb_t;
  typedef logic signed [DIFF_W-1:0] diff_t;
  typedef logic [DIFF_W-1:0]        dist_t;

  localparam coord_t COORD_MAX = '1;

  // One beat of the video stream as it travels down the delay line.
  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
    rgb_t pixel;
  } video_beat_t;

  function automatic logic rise_edge(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

  function automatic logic fall_edge(input logic cur, input logic prev);
    return ~cur & prev;
  endfunction

  // Counters stick at the top value instead of wrapping to 0.
  function automatic coord_t sat_inc(input coord_t v);
    return (v == COORD_MAX) ? v : v + coord_t'(1);
  endfunction

  // Signed distance between two unsigned coordinates.
  function automatic diff_t coord_diff(input coord_t a, input coord_t b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  // Magnitude of a difference; operands never reach the most negative value.
  function automatic dist_t coord_dist(input diff_t d);
    return d[DIFF_W-1] ? dist_t'(-d) : dist_t'(d);
  endfunction

endpackage

// File: rtl/video_pos_counter.sv
// Tracks the column/row of the pixel currently on the input from de and vsync.
// col/row describe the present cycle; frame_start flags the vsync rising edge.
module video_pos_counter
  import video_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               de,
  input  logic               vsync,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic               frame_start
);

  logic   de_q;
  logic   vsync_q;
  logic   line_end;
  coord_t col_cnt;
  coord_t row_cnt;

  always_comb begin
    frame_start = rise_edge(vsync, vsync_q);
    line_end    = fall_edge(de, de_q);
    // A pixel coinciding with the vsync rise already belongs to the new frame.
    col         = frame_start ? '0 : col_cnt;
    row         = frame_start ? '0 : row_cnt;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q    <= 1'b0;
      vsync_q <= 1'b0;
      col_cnt <= '0;
      row_cnt <= '0;
    end else begin
      de_q    <= de;
      vsync_q <= vsync;
      if (frame_start) begin
        col_cnt <= {{(COORD_W-1){1'b0}}, de};
        row_cnt <= '0;
      end else if (line_end) begin
        col_cnt <= '0;
        row_cnt <= sat_inc(row_cnt);
      end else if (de) begin
        col_cnt <= sat_inc(col_cnt);
      end
    end
  end

endmodule

// File: rtl/centroid_marker.sv
// Draws a clipped crosshair at the latched centroid onto a passing video stream.
// Stage 1 registers the beat and the hit flag; stage 2 applies the overlay colour.
module centroid_marker
  import video_pkg::*;
#(
  parameter int          IMG_W    = DEF_IMG_W,
  parameter int          IMG_H    = DEF_IMG_H,
  parameter int          ARM_LEN  = 4,
  parameter logic [23:0] MARK_RGB = 24'hFF0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        de,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [23:0] pixel_in,
  input  logic [10:0] x,
  input  logic [10:0] y,
  input  logic        enable,
  output logic        de_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic [23:0] pixel_out,
  output logic        mark_valid
);

  localparam coord_t IMG_W_C = coord_t'(IMG_W);
  localparam coord_t IMG_H_C = coord_t'(IMG_H);
  localparam dist_t  ARM_LIM = dist_t'(ARM_LEN);

  coord_t      col;
  coord_t      row;
  logic        frame_start;

  coord_t      xc;
  coord_t      yc;
  coord_t      cx;
  coord_t      cy;
  logic        valid_now;
  logic        centroid_ok;
  logic        pos_in_img;
  dist_t       dx_abs;
  dist_t       dy_abs;
  logic        on_vert_arm;
  logic        on_horz_arm;
  logic        hit;

  video_beat_t s1_beat;
  logic        s1_hit;

  video_pos_counter u_pos (
    .clk         (clk),
    .rst_n       (rst_n),
    .de          (de),
    .vsync       (vsync),
    .col         (col),
    .row         (row),
    .frame_start (frame_start)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xc         <= '0;
      yc         <= '0;
      mark_valid <= 1'b0;
    end else if (frame_start) begin
      xc         <= x;
      yc         <= y;
      mark_valid <= 1'b1;
    end
  end

  // The frame-start pixel already uses the freshly captured centroid.
  always_comb begin
    cx          = frame_start ? x : xc;
    cy          = frame_start ? y : yc;
    valid_now   = frame_start | mark_valid;
    centroid_ok = (cx < IMG_W_C) && (cy < IMG_H_C);
    pos_in_img  = (col < IMG_W_C) && (row < IMG_H_C);
    dx_abs      = coord_dist(coord_diff(col, cx));
    dy_abs      = coord_dist(coord_diff(row, cy));
    on_vert_arm = (col == cx) && (dy_abs <= ARM_LIM);
    on_horz_arm = (row == cy) && (dx_abs <= ARM_LIM);
    hit         = de && enable && valid_now && centroid_ok && pos_in_img &&
                  (on_vert_arm || on_horz_arm);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_beat <= '0;
      s1_hit  <= 1'b0;
    end else begin
      s1_beat <= '{de: de, hsync: hsync, vsync: vsync, pixel: pixel_in};
      s1_hit  <= hit;
    end
  end

  // hit is only ever set alongside de, so blanking pixels pass unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_out    <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      pixel_out <= '0;
    end else begin
      de_out    <= s1_beat.de;
      hsync_out <= s1_beat.hsync;
      vsync_out <= s1_beat.vsync;
      pixel_out <= s1_hit ? MARK_RGB : s1_beat.pixel;
    end
  end

endmodule

// File: tb/tb_centroid_marker.sv
// Self-checking bench for centroid_marker: frame-level stimulus with a pixel
// model that knows each pixel's (row, col) from the generator loops.
module tb_centroid_marker;

  localparam int          W      = 64;
  localparam int          H      = 64;
  localparam int          ARM    = 4;
  localparam logic [23:0] MARK   = 24'hFF0000;
  localparam int          HBLANK = 4;
  localparam int          VLINES = 2;
  localparam int          LINE_T = W + HBLANK;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        de, hsync, vsync, enable;
  logic [23:0] pixel_in, pixel_out;
  logic [10:0] x, y;
  logic        de_out, hsync_out, vsync_out, mark_valid;

  always #5 clk = ~clk;

  centroid_marker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .de         (de),
    .hsync      (hsync),
    .vsync      (vsync),
    .pixel_in   (pixel_in),
    .x          (x),
    .y          (y),
    .enable     (enable),
    .de_out     (de_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .pixel_out  (pixel_out),
    .mark_valid (mark_valid)
  );

  typedef struct {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] pix;
  } beat_t;

  int     checks = 0;
  int     errors = 0;
  beat_t  hist[$];
  int     m_cx, m_cy;
  bit     mv;
  logic   prev_vs;
  int     dut_marks;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Crosshair membership straight from the geometric definition.
  function automatic bit on_cross(input int r, input int c);
    if (!mv) return 1'b0;
    if (m_cx >= W || m_cy >= H) return 1'b0;
    if (r < 0 || r >= H || c < 0 || c >= W) return 1'b0;
    return (c == m_cx && (r - m_cy) <= ARM && (m_cy - r) <= ARM) ||
           (r == m_cy && (c - m_cx) <= ARM && (m_cx - c) <= ARM);
  endfunction

  function automatic logic [23:0] rand_pix();
    logic [23:0] p;
    do p = 24'($urandom); while (p == MARK);
    return p;
  endfunction

  task automatic seed_pipeline();
    beat_t z;
    z.de = 1'b0; z.hs = 1'b0; z.vs = 1'b0; z.pix = '0;
    hist.delete();
    hist.push_back(z);
    hist.push_back(z);
    mv      = 1'b0;
    prev_vs = 1'b0;
  endtask

  task automatic step(input logic d, input logic hs, input logic vs,
                      input logic [23:0] p, input logic en, input int r, input int c);
    beat_t b, e;
    @(negedge clk);
    if (hist.size() == 2) begin
      e = hist.pop_front();
      check("sync", {29'b0, de_out, hsync_out, vsync_out}, {29'b0, e.de, e.hs, e.vs});
      check("pixel", {8'b0, pixel_out}, {8'b0, e.pix});
      if (de_out && pixel_out == MARK) dut_marks++;
    end
    check("mark_valid", {31'b0, mark_valid}, {31'b0, mv});
    de = d; hsync = hs; vsync = vs; pixel_in = p; enable = en;
    if (vs && !prev_vs) begin
      m_cx = int'(x);
      m_cy = int'(y);
      mv   = 1'b1;
    end
    prev_vs = vs;
    b.de  = d;
    b.hs  = hs;
    b.vs  = vs;
    b.pix = (d && en && on_cross(r, c)) ? MARK : p;
    hist.push_back(b);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sync"}, {29'b0, de_out, hsync_out, vsync_out}, 32'd0);
    check({tag, "_pixel"}, {8'b0, pixel_out}, 32'd0);
    check({tag, "_mark_valid"}, {31'b0, mark_valid}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    de = 1'b0; hsync = 1'b0; vsync = 1'b0; pixel_in = '0;
    #1;
    check_reset_outputs("midframe_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seed_pipeline();
  endtask

  // en_mode: 0 off, 1 on, 2 random per pixel. rst_row < 0 means no reset.
  task automatic run_frame(input int fx, input int fy, input int mx, input int my,
                           input int en_mode, input int rst_row, input int exp_marks);
    logic en, hs, d;
    x = 11'(fx);
    y = 11'(fy);
    dut_marks = 0;
    for (int vl = 0; vl < VLINES; vl++) begin
      for (int c = 0; c < LINE_T; c++) begin
        hs = (c >= LINE_T - 2);
        step(1'b0, hs, (vl == 0), rand_pix(), 1'b1, -1, c);
      end
    end
    for (int r = 0; r < H; r++) begin
      if (r == 32) begin
        x = 11'(mx);
        y = 11'(my);
      end
      for (int c = 0; c < LINE_T; c++) begin
        if (r == rst_row && c == 10) do_reset();
        d  = (c < W);
        hs = (c >= LINE_T - 2);
        en = (en_mode == 2) ? logic'($urandom_range(0, 1)) : (en_mode == 1);
        step(d, hs, 1'b0, rand_pix(), en, r, c);
      end
    end
    if (exp_marks >= 0) check("frame_marks", 32'(dut_marks), 32'(exp_marks));
  endtask

  initial begin
    rst_n = 1'b0;
    de = 1'b0; hsync = 1'b0; vsync = 1'b0; enable = 1'b0;
    pixel_in = '0; x = '0; y = '0;
    seed_pipeline();
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_frame(70, 70, 70, 70, 1, -1, 0);   // first frame, centroid off-image
    run_frame(10, 20, 10, 20, 1, -1, 17);  // full cross
    run_frame(1, 62, 1, 62, 1, -1, 11);    // clipped at left and bottom edges
    run_frame(64, 5, 64, 5, 1, -1, 0);     // x just outside the image
    run_frame(30, 30, 30, 30, 0, -1, 0);   // overlay disabled
    run_frame(10, 20, 10, 20, 1, 30, -1);  // reset mid-frame
    run_frame(33, 12, 33, 12, 1, -1, 17);  // marker returns after next vsync
    run_frame(10, 20, 40, 40, 1, -1, 17);  // mid-frame x/y change ignored
    run_frame(40, 40, 40, 40, 1, -1, 17);  // new centroid takes effect
    for (int i = 0; i < 3; i++) begin
      int rx, ry;
      rx = $urandom_range(0, 70);
      ry = $urandom_range(0, 70);
      run_frame(rx, ry, $urandom_range(0, 70), $urandom_range(0, 70), 2, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
